// File: rtl/spi_flash_reader.sv
// SPI NOR read engine: issues 0x03 READ frames in mode 0
// and streams the returned bytes out over a valid/ready port.
module spi_flash_reader #(
    parameter int CLK_DIV      = 2,
    parameter int DESEL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic        done,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
    localparam logic [7:0] DESEL_M1 = 8'(DESEL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_DESEL
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_csb;
    logic        r_sck;
    logic        r_io0;
    logic        r_valid;
    logic        r_done;
    logic        r_load;
    logic [7:0]  r_data;
    logic [7:0]  r_shin;
    logic [7:0]  r_div;
    logic [7:0]  r_tmr;
    logic [31:0] r_sh;
    logic [4:0]  r_bit;
    logic [8:0]  r_bytes;

    logic        w_accept;
    logic        w_shift;
    logic        w_div_end;
    logic        w_stall;
    logic        w_rise;
    logic        w_fall;
    logic [31:0] w_frame;

    assign w_frame   = {8'h03, cmd_addr};
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_shift   = (r_state == S_CMD) || (r_state == S_ADDR)
                    || (r_state == S_DATA);
    assign w_div_end = (r_div == DIV_M1);
    // Hold SCK low before the last bit of a byte while the previous one is unread
    assign w_stall   = (r_state == S_DATA) && !r_sck
                    && (r_bit[2:0] == 3'd7) && r_valid && !out_ready;
    assign w_rise    = w_shift && !r_sck && w_div_end && !w_stall;
    assign w_fall    = w_shift && r_sck && w_div_end;

    assign cmd_ready = (r_state == S_IDLE) && !r_valid;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign flash_csb = r_csb;
    assign flash_clk = r_sck;
    assign flash_io0 = r_io0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CMD;
            S_CMD:   if (w_fall && r_bit == 5'd0) w_next = S_ADDR;
            S_ADDR:  if (w_fall && r_bit == 5'd0) w_next = S_DATA;
            S_DATA:  if (w_fall && r_bit[2:0] == 3'd7 && r_bytes == 9'd1)
                         w_next = S_HOLD;
            S_HOLD:  if (w_div_end) w_next = S_DESEL;
            S_DESEL: if (r_tmr == 8'd0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_csb   <= 1'b1;
            r_sck   <= 1'b0;
            r_io0   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_load  <= 1'b0;
            r_data  <= '0;
            r_shin  <= '0;
            r_div   <= '0;
            r_tmr   <= '0;
            r_sh    <= '0;
            r_bit   <= '0;
            r_bytes <= '0;
        end else begin
            r_done <= 1'b0;
            r_load <= 1'b0;
            if (r_valid && out_ready) r_valid <= 1'b0;
            if (r_load) begin
                r_valid <= 1'b1;
                r_data  <= r_shin;
            end
            if (w_shift) begin
                if (w_rise || w_fall) r_div <= '0;
                else if (!w_stall)    r_div <= r_div + 8'd1;
                if (w_rise) r_sck <= 1'b1;
                if (w_fall) r_sck <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: if (w_accept) begin
                    r_csb   <= 1'b0;
                    r_sck   <= 1'b0;
                    r_io0   <= w_frame[31];
                    r_sh    <= w_frame;
                    r_bit   <= 5'd7;
                    r_div   <= '0;
                    r_bytes <= (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
                end
                S_CMD, S_ADDR: if (w_fall) begin
                    r_sh  <= {r_sh[30:0], 1'b0};
                    r_io0 <= r_sh[30];
                    if (r_bit != 5'd0)       r_bit <= r_bit - 5'd1;
                    else if (r_state == S_CMD) r_bit <= 5'd23;
                end
                S_DATA: if (w_fall) begin
                    r_shin <= {r_shin[6:0], flash_io1};
                    r_bit  <= {2'b00, r_bit[2:0] + 3'd1};
                    if (r_bit[2:0] == 3'd7) begin
                        r_load  <= 1'b1;
                        r_bytes <= r_bytes - 9'd1;
                    end
                end
                S_HOLD: begin
                    if (w_div_end) begin
                        r_csb  <= 1'b1;
                        r_done <= 1'b1;
                        r_tmr  <= DESEL_M1;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                S_DESEL: if (r_tmr != 8'd0) r_tmr <= r_tmr - 8'd1;
                default: ;
            endcase
        end
    end

endmodule
